pe_layer_collector: RTL
=======================

Name: pe_layer_collector

Overview:
Downstream neighbour of the processing element. Captures the quantized activation the PE produces for each neuron of a layer (one result per INPUT_NUM-long accumulation) into a local buffer. Once all NUM_NEURONS results are present, it streams them in neuron order to the next layer's input feeder over a valid/ready handshake. Single bank: fill and drain phases alternate and never overlap.

Parameters:
OUT_W, 8, width of one PE activation (matches PE out_n)
NUM_NEURONS, 4, activations per layer; must be >= 2
CNT_W, $clog2(NUM_NEURONS+1), derived width of the fill/drain counters; not to be overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
pe_valid  input  1  one-cycle strobe: pe_out holds a finished neuron activation
pe_out  input  OUT_W  quantized activation from the PE
pe_ready  output  1  high in FILL: the collector accepts pe_valid
nxt_valid  output  1  nxt_data is valid toward the next layer
nxt_data  output  OUT_W  activation currently offered
nxt_last  output  1  high with nxt_valid on neuron NUM_NEURONS-1
nxt_ready  input  1  next layer accepts nxt_data this cycle
layer_done  output  1  one-cycle pulse after the last drain handshake
overflow  output  1  sticky: pe_valid arrived while pe_ready=0
clr_overflow  input  1  synchronous clear of overflow

Behaviour:
- reset low (async): state=FILL, wr_cnt=0, rd_cnt=0. Outputs: pe_ready=1, nxt_valid=0, nxt_data=0, nxt_last=0, layer_done=0, overflow=0. Buffer contents are don't-care.
- FILL:
  - pe_valid=1 writes pe_out to buf[wr_cnt] and increments wr_cnt.
  - On the write that brings wr_cnt to NUM_NEURONS: next state DRAIN, wr_cnt->0, rd_cnt->0, pe_ready drops the following cycle.
  - nxt_valid=0 throughout FILL.
- DRAIN:
  - nxt_valid=1 is registered. It first rises 1 cycle after the final FILL write; in that same cycle nxt_data=buf[0].
  - Handshake is nxt_valid & nxt_ready. On a handshake, rd_cnt increments and nxt_data/nxt_last update in the next cycle to buf[rd_cnt+1], giving back-to-back throughput of 1 word/cycle.
  - nxt_valid and nxt_data must hold stable while nxt_ready=0. No data is dropped.
  - nxt_last=1 exactly while rd_cnt==NUM_NEURONS-1.
  - A handshake with nxt_last=1 returns the block to FILL next cycle: nxt_valid->0, pe_ready->1, layer_done=1 for one cycle, nxt_last->0.
- Overflow:
  - pe_valid while pe_ready=0 (DRAIN, or the transition cycle) is discarded: no buffer or counter change, and overflow is set.
  - clr_overflow clears overflow; if set and clear occur in the same cycle, set wins.
- There is no bypass. A pe_valid arriving in the cycle FILL->DRAIN is decided by registered pe_ready=0, so it is an overflow.
- Reset asserted mid-DRAIN aborts the drain. Outputs return to their reset values immediately (async); the partial layer is lost.
- nxt_data holds its last value when nxt_valid=0. It does not clear except on reset.
- No arithmetic on data: values are passed bit-exact. Counters never exceed NUM_NEURONS-1 outside the transition cycle.

Test Plan:
- Reset, then pe_valid with pe_out=0x11,0x22,0x33,0x44 on consecutive cycles, nxt_ready=1 -> nxt_valid high from cycle 5. nxt_data=0x11,0x22,0x33,0x44 on successive cycles, nxt_last only with 0x44, layer_done pulse on the next cycle, pe_ready=1 again.
- Same fill, nxt_ready toggled 1,0,0,1,1,0,1 -> each word held stable while ready=0. Exactly 4 handshakes in order 0x11..0x44, no duplicates.
- During DRAIN, pulse pe_valid with 0x7F -> overflow=1 and stays set. Drained data is unchanged. clr_overflow for one cycle -> overflow=0. clr_overflow and illegal pe_valid in the same cycle -> overflow=1.
- Two full layers back-to-back (0x01..0x04 then 0x81..0x84) with gaps in pe_valid -> second layer drains 0x81..0x84. Two layer_done pulses total.
- Assert reset low asynchronously after 2 of 4 drain handshakes -> nxt_valid, nxt_last, nxt_data go to 0 without a clock edge. After release, a new fill of 0x05..0x08 drains correctly from buf[0].
- NUM_NEURONS=2 build, pe_out 0xFF,0x80 -> drain order 0xFF then 0x80 with nxt_last, sign bits preserved.

Source files
------------

// File: rtl/pe_layer_collector.sv
// pe_layer_collector: buffers one layer of PE activations, then streams them
// in neuron order to the next layer over a valid/ready handshake. One bank,
// so the FILL and DRAIN phases strictly alternate.
module pe_layer_collector #(
  parameter int OUT_W       = 8,
  parameter int NUM_NEURONS = 4,
  parameter int CNT_W       = $clog2(NUM_NEURONS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pe_valid,
  input  logic [OUT_W-1:0] pe_out,
  output logic             pe_ready,
  output logic             nxt_valid,
  output logic [OUT_W-1:0] nxt_data,
  output logic             nxt_last,
  input  logic             nxt_ready,
  output logic             layer_done,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NEURONS - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] wr_cnt, wr_cnt_n;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_n;
  logic [CNT_W-1:0] rd_inc;
  logic             nxt_valid_n, nxt_last_n, layer_done_n, overflow_n;
  logic [OUT_W-1:0] nxt_data_n;
  logic             mem_we;
  logic [OUT_W-1:0] mem [NUM_NEURONS];

  // The collector only listens to the PE while filling.
  assign pe_ready = (state == FILL);
  assign rd_inc   = rd_cnt + CNT_W'(1);

  // Next-state and next-output decode for both phases.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned; that is what keeps this block free of latches.
    state_n      = state;
    wr_cnt_n     = wr_cnt;
    rd_cnt_n     = rd_cnt;
    nxt_valid_n  = nxt_valid;
    nxt_data_n   = nxt_data;
    nxt_last_n   = nxt_last;
    layer_done_n = 1'b0;
    mem_we       = 1'b0;
    // A strobe the collector cannot take is dropped and remembered; a set
    // in the same cycle as a clear wins.
    overflow_n   = (overflow & ~clr_overflow) | (pe_valid & ~pe_ready);

    case (state)
      FILL: begin
        if (pe_valid) begin
          mem_we = 1'b1;
          if (wr_cnt == LAST) begin
            // Final word of the layer: start offering buf[0] next cycle.
            // buf[0] was written on an earlier cycle, so it is safe to read.
            state_n     = DRAIN;
            wr_cnt_n    = '0;
            rd_cnt_n    = '0;
            nxt_valid_n = 1'b1;
            nxt_data_n  = mem[0];
            nxt_last_n  = 1'b0;
          end else begin
            wr_cnt_n = wr_cnt + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (nxt_valid && nxt_ready) begin
          if (nxt_last) begin
            // Last word taken: back to FILL, nxt_data keeps its last value.
            state_n      = FILL;
            rd_cnt_n     = '0;
            nxt_valid_n  = 1'b0;
            nxt_last_n   = 1'b0;
            layer_done_n = 1'b1;
          end else begin
            rd_cnt_n   = rd_inc;
            nxt_data_n = mem[rd_inc[IDX_W-1:0]];
            nxt_last_n = (rd_inc == LAST);
          end
        end
      end
      default: state_n = FILL;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      nxt_valid  <= 1'b0;
      nxt_data   <= '0;
      nxt_last   <= 1'b0;
      layer_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state      <= state_n;
      wr_cnt     <= wr_cnt_n;
      rd_cnt     <= rd_cnt_n;
      nxt_valid  <= nxt_valid_n;
      nxt_data   <= nxt_data_n;
      nxt_last   <= nxt_last_n;
      layer_done <= layer_done_n;
      overflow   <= overflow_n;
    end
  end

  // Activation buffer write port.
  // NOTE: the buffer has no reset; its contents are only read after being
  // written in the current layer, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_cnt[IDX_W-1:0]] <= pe_out;
  end

endmodule
